// File: rtl/ula_seq.sv
// Registered ALU with a start/busy/done handshake.
// Mul and Div are multi-cycle; every other op completes in one cycle.
module ula_seq #(
    parameter int WIDTH      = 16,
    parameter bit SIGNED_CMP = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [4:0]         opcode,
    input  logic [WIDTH-1:0]   operando1,
    input  logic [WIDTH-1:0]   operando2,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] resultado,
    output logic               data_uc,
    output logic               div_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [4:0] OP_PUSH  = 5'b00010;
    localparam logic [4:0] OP_ADD   = 5'b00100;
    localparam logic [4:0] OP_SUB   = 5'b00101;
    localparam logic [4:0] OP_MUL   = 5'b00110;
    localparam logic [4:0] OP_DIV   = 5'b00111;
    localparam logic [4:0] OP_AND   = 5'b01000;
    localparam logic [4:0] OP_NAND  = 5'b01001;
    localparam logic [4:0] OP_OR    = 5'b01010;
    localparam logic [4:0] OP_XOR   = 5'b01011;
    localparam logic [4:0] OP_CMP   = 5'b01100;
    localparam logic [4:0] OP_NOT   = 5'b01101;
    localparam logic [4:0] OP_IF_EQ = 5'b01111;
    localparam logic [4:0] OP_IF_GT = 5'b10000;
    localparam logic [4:0] OP_IF_LT = 5'b10001;
    localparam logic [4:0] OP_IF_GE = 5'b10010;
    localparam logic [4:0] OP_IF_LE = 5'b10011;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIN
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_nx;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   rem_nx;
    logic [WIDTH-1:0]   quo_nx;

    logic               div0;
    logic               eq_ab;
    logic               gt_ab;
    logic               neg_a;
    logic               zero_a;
    logic [2*WIDTH-1:0] alu_res;
    logic               alu_flag;
    logic               is_branch;

    logic [WIDTH-1:0]   zw;

    assign zw   = '0;
    assign div0 = (opcode == OP_DIV) && (operando2 == '0);
    assign busy = (state == MUL) || (state == DIV);
    assign done = (state == FIN);

    // Next-state logic; FIN accepts a new start just like IDLE
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, FIN: begin
                if (start) begin
                    if (opcode == OP_MUL)
                        state_nx = MUL;
                    else if (opcode == OP_DIV && !div0)
                        state_nx = DIV;
                    else
                        state_nx = FIN;
                end else begin
                    state_nx = IDLE;
                end
            end
            MUL: if (cnt == LAST) state_nx = FIN;
            DIV: if (cnt == LAST) state_nx = FIN;
        endcase
    end

    // Single-cycle results and branch flags, computed from the live inputs
    always_comb begin
        alu_res   = '0;
        alu_flag  = 1'b0;
        is_branch = 1'b0;
        eq_ab     = (operando1 == operando2);
        if (SIGNED_CMP)
            gt_ab = $signed(operando1) > $signed(operando2);
        else
            gt_ab = operando1 > operando2;
        neg_a  = SIGNED_CMP && operando1[WIDTH-1];
        zero_a = (operando1 == '0);
        case (opcode)
            OP_PUSH: alu_res = {zw, operando1};
            OP_ADD:  alu_res = {zw, operando1} + {zw, operando2};
            OP_SUB:  alu_res = {zw, operando1} - {zw, operando2};
            OP_AND:  alu_res = {zw, operando1 & operando2};
            OP_NAND: alu_res = {zw, ~(operando1 & operando2)};
            OP_OR:   alu_res = {zw, operando1 | operando2};
            OP_XOR:  alu_res = {zw, operando1 ^ operando2};
            OP_NOT:  alu_res = {zw, ~operando1};
            OP_CMP: begin
                if (eq_ab)
                    alu_res = '0;
                else if (gt_ab)
                    alu_res = {{(2*WIDTH-1){1'b0}}, 1'b1};
                else
                    alu_res = '1;
            end
            OP_IF_EQ: begin
                is_branch = 1'b1;
                alu_flag  = zero_a;
            end
            OP_IF_GT: begin
                is_branch = 1'b1;
                alu_flag  = !zero_a && !neg_a;
            end
            OP_IF_LT: begin
                is_branch = 1'b1;
                alu_flag  = neg_a;
            end
            OP_IF_GE: begin
                is_branch = 1'b1;
                alu_flag  = !neg_a;
            end
            OP_IF_LE: begin
                is_branch = 1'b1;
                alu_flag  = zero_a || neg_a;
            end
            default: alu_res = '0;
        endcase
    end

    // One shift-add step and one restoring-divide step per cycle
    always_comb begin
        prod_nx = prod + (mplier[0] ? mcand : '0);
        rem_sh  = {rem, quo[WIDTH-1]};
        diff    = rem_sh - {1'b0, divisor};
        if (!diff[WIDTH]) begin
            rem_nx = diff[WIDTH-1:0];
            quo_nx = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nx = rem_sh[WIDTH-1:0];
            quo_nx = {quo[WIDTH-2:0], 1'b0};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Operand capture, iteration registers and result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            quo       <= '0;
            divisor   <= '0;
            rem       <= '0;
            resultado <= '0;
            data_uc   <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    if (start) begin
                        cnt <= '0;
                        if (opcode == OP_MUL) begin
                            mcand  <= {zw, operando1};
                            mplier <= operando2;
                            prod   <= '0;
                        end else if (div0) begin
                            resultado <= '0;
                            data_uc   <= 1'b0;
                            div_zero  <= 1'b1;
                        end else if (opcode == OP_DIV) begin
                            quo     <= operando1;
                            divisor <= operando2;
                            rem     <= '0;
                        end else begin
                            if (!is_branch)
                                resultado <= alu_res;
                            data_uc  <= is_branch && alu_flag;
                            div_zero <= 1'b0;
                        end
                    end
                end
                MUL: begin
                    prod   <= prod_nx;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        resultado <= prod_nx;
                        data_uc   <= 1'b0;
                        div_zero  <= 1'b0;
                    end
                end
                DIV: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        resultado <= {rem_nx, quo_nx};
                        data_uc   <= 1'b0;
                        div_zero  <= 1'b0;
                    end
                end
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
- Parametrised, registered successor to the processor's combinational ALU.
- Keeps the same 5-bit opcode encoding.
- Adds a start/busy/done handshake, multi-cycle shift-add multiply and restoring divide, and a divide-by-zero flag.
- Adds optional signed comparisons for Cmp and the If_* branch tests; the control unit launches an operation and waits on done.

Parameters:
- WIDTH, 16, operand width in bits; resultado is 2*WIDTH.
- SIGNED_CMP, 1, 1 = Cmp/If_* treat operands as two's complement; 0 = unsigned.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  launch request; sampled only when busy=0
- opcode  in  5  operation select
- operando1  in  WIDTH  first operand
- operando2  in  WIDTH  second operand
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; resultado/data_uc/div_zero are valid from this cycle
- resultado  out  2*WIDTH  registered result
- data_uc  out  1  branch-condition flag for the control unit
- div_zero  out  1  set when Div is issued with operando2=0

Behaviour:
- Reset: on a clock edge with reset=1, state=IDLE and busy, done, data_uc, div_zero=0, resultado=0. This applies mid-operation too: any Mul/Div in flight is aborted and no done is issued.
- Operand capture: on an edge with start=1 and busy=0, opcode and both operands are captured. start while busy=1 is ignored (no queueing). Input changes after capture have no effect.
- Outputs hold their last values until the next done; done is exactly one cycle wide.
- States: IDLE, MUL, DIV, FIN.
- Single-cycle ops, IDLE->FIN on capture; done=1 in the cycle after capture:
  - Push(00010): resultado = zero-extended operando1.
  - Add(00100): resultado = zero-extended operando1+operando2, carry in bit WIDTH.
  - Sub(00101): resultado = operando1-operando2 in 2*WIDTH two's complement.
  - And(01000), Nand(01001), Or(01010), Xor(01011): bitwise on WIDTH bits, upper bits 0.
  - Not(01101): ~operando1 on WIDTH bits, upper bits 0.
  - Cmp(01100): resultado = 0 if equal, 1 if operando1>operando2, all-ones if less.
- Branch ops If_eq(01111), If_gt(10000), If_lt(10001), If_ge(10010), If_le(10011):
  - data_uc = (operando1 ==, >, <, >=, <= 0 respectively); resultado is unchanged.
  - With SIGNED_CMP=1, operando1 is signed. With SIGNED_CMP=0, If_lt is always 0 and If_ge always 1.
- Any other opcode: resultado=0, data_uc=0, done after one cycle.
- data_uc is cleared on every done that is not a branch op. div_zero is cleared on every done except Div with operando2=0.
- Mul(00110): IDLE->MUL, unsigned shift-add, one partial-product bit per cycle for WIDTH cycles, then FIN.
  - done asserts WIDTH+1 cycles after the capture edge.
  - resultado is the full 2*WIDTH product.
- Div(00111): IDLE->DIV, unsigned restoring division, WIDTH cycles, then FIN; done at WIDTH+1 cycles.
  - resultado[WIDTH-1:0] = quotient; resultado[2*WIDTH-1:WIDTH] = remainder.
  - If operando2=0: no DIV state; FIN next cycle with resultado=0 and div_zero=1.
- FIN: done=1, busy=0, return to IDLE.
  - busy=1 from the cycle after capture through the cycle before done.
  - start asserted in the FIN cycle is accepted, giving back-to-back operations.
- Zero-operand Mul still runs the full WIDTH cycles (constant latency).

Test Plan (WIDTH=16, SIGNED_CMP=1):
- Add 16'hFFFF + 16'h0001 -> done one cycle after start; resultado=32'h0001_0000; data_uc=0.
- Mul 16'hFFFF * 16'hFFFF -> busy for 16 cycles; done at cycle 17; resultado=32'hFFFE_0001. A second start during busy is ignored.
- Div 100/7 -> done at cycle 17; resultado=32'h0002_000E. Then Div 5/0 -> done next cycle; resultado=0; div_zero=1.
- Cmp 3 vs 5 -> resultado=32'hFFFF_FFFF. Cmp 5 vs 5 -> resultado=0. Then If_lt with operando1=16'h8000 -> data_uc=1, resultado unchanged.
- Assert reset for one cycle at cycle 8 of a Mul -> no done pulse; all outputs 0; busy=0. Next Add 2+3 -> resultado=5.
- Back-to-back: Add issued in the FIN cycle of a Div -> Add done exactly one cycle after the Div done.
